// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/sub unit.
// Imported by the top module and by benches that need the mode encoding.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int   ADDSUB_WIDTH = 8;
   localparam logic MODE_ADD     = 1'b0;
   localparam logic MODE_SUB     = 1'b1;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit combinational full adder.
// This is the only arithmetic in the serial datapath.
module serial_fa_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's complement adder/subtractor, LSB first, one bit per clock.
// Subtraction is done as a + ~b + 1, with the +1 entering through the initial carry.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = ADDSUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             m,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic             carry_reg;
   logic [CW-1:0]    cnt_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             ovf_reg;

   logic             fa_s;
   logic             fa_cout;
   logic [WIDTH-1:0] res_next;

   serial_fa_bit u_fa (
      .x    (a_reg[0]),
      .y    (b_reg[0]),
      .cin  (carry_reg),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign res_next = {fa_s, res_reg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         sum_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b ^ {WIDTH{m}};
                  carry_reg <= m;
                  cnt_reg   <= '0;
                  res_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end else begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
               b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
               carry_reg <= fa_cout;
               res_reg   <= res_next;
               if (cnt_reg == LAST) begin
                  // carry_reg here is the carry into the sign bit
                  sum_reg   <= res_next;
                  ovf_reg   <= carry_reg ^ fa_cout;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  cnt_reg   <= cnt_reg + 1'b1;
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign sum  = sum_reg;
   assign ovf  = ovf_reg;

endmodule
